// File: rtl/l1d_queue_pkg.sv
// Shared sizing helpers for the L1D multi-port queues (MSHR, writeback, store buffer).
package l1d_queue_pkg;

    function automatic int calc_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int calc_tag_w(input int depth, input int flag_en);
        return calc_ptr_w(depth) + flag_en;
    endfunction

    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Drops the manager's wrap flag; the low bits are the storage index.
    function automatic int unsigned tag_idx(input int unsigned tag, input int ptr_bits);
        return tag & ((32'd1 << ptr_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/mport_queue_lane_gate.sv
// Prefix-contiguous lane handshake: lane i opens only if cnt > i and all lower partner lanes are asserted.
module mport_queue_lane_gate #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 4
) (
    input  logic             kill,
    input  logic [CNT_W-1:0] cnt,
    input  logic [WIDTH-1:0] partner,
    output logic [WIDTH-1:0] gate,
    output logic [WIDTH-1:0] fire
);

    logic [WIDTH-1:0] pfx;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        if (i == 0) begin : g_first
            assign pfx[i] = 1'b1;
        end else begin : g_rest
            assign pfx[i] = pfx[i-1] & partner[i-1];
        end
        assign gate[i] = !kill && (32'(cnt) > i) && pfx[i];
        assign fire[i] = gate[i] & partner[i];
    end

endmodule

// File: rtl/mport_queue_datapath.sv
// Flop-array storage and lane handshakes for a multi-port in-order queue.
// Pointers and usage live in the companion manager; this block consumes its tags/avail.
module mport_queue_datapath
    import l1d_queue_pkg::*;
#(
    parameter int ENTRY_COUNT = 8,
    parameter int ENQ_WIDTH   = 2,
    parameter int DEQ_WIDTH   = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int FLAG_EN     = 0,
    localparam int PTR_W      = calc_ptr_w(ENTRY_COUNT),
    localparam int TAG_W      = calc_tag_w(ENTRY_COUNT, FLAG_EN),
    localparam int CNT_W      = calc_cnt_w(ENTRY_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush_i,
    input  logic [ENQ_WIDTH-1:0]                 enq_vld_i,
    input  logic [ENQ_WIDTH-1:0][DATA_WIDTH-1:0] enq_data_i,
    output logic [ENQ_WIDTH-1:0]                 enq_rdy_o,
    output logic [DEQ_WIDTH-1:0]                 deq_vld_o,
    output logic [DEQ_WIDTH-1:0][DATA_WIDTH-1:0] deq_data_o,
    input  logic [DEQ_WIDTH-1:0]                 deq_rdy_i,
    input  logic [ENQ_WIDTH-1:0][TAG_W-1:0]      um_tail_i,
    input  logic [DEQ_WIDTH-1:0][TAG_W-1:0]      um_head_i,
    input  logic [CNT_W-1:0]                     um_avail_cnt_i,
    output logic [ENQ_WIDTH-1:0]                 um_enq_fire_o,
    output logic [DEQ_WIDTH-1:0]                 um_deq_fire_o,
    output logic                                 err_o
);

    logic [ENTRY_COUNT-1:0][DATA_WIDTH-1:0] mem;
    logic [ENTRY_COUNT-1:0]                 entry_vld, vld_nxt;
    logic [ENQ_WIDTH-1:0][PTR_W-1:0]        wr_idx;
    logic [DEQ_WIDTH-1:0][PTR_W-1:0]        rd_idx;
    logic [ENQ_WIDTH-1:0]                   enq_fire;
    logic [DEQ_WIDTH-1:0]                   deq_fire;
    logic [CNT_W-1:0]                       occ;
    logic                                   err_q, err_hit;

    assign occ = CNT_W'(ENTRY_COUNT) - um_avail_cnt_i;

    mport_queue_lane_gate #(.WIDTH(ENQ_WIDTH), .CNT_W(CNT_W)) u_enq_gate (
        .kill    (flush_i),
        .cnt     (um_avail_cnt_i),
        .partner (enq_vld_i),
        .gate    (enq_rdy_o),
        .fire    (enq_fire)
    );

    mport_queue_lane_gate #(.WIDTH(DEQ_WIDTH), .CNT_W(CNT_W)) u_deq_gate (
        .kill    (flush_i),
        .cnt     (occ),
        .partner (deq_rdy_i),
        .gate    (deq_vld_o),
        .fire    (deq_fire)
    );

    assign um_enq_fire_o = enq_fire;
    assign um_deq_fire_o = deq_fire;
    assign err_o         = err_q;

    for (genvar i = 0; i < ENQ_WIDTH; i++) begin : g_wr
        assign wr_idx[i] = PTR_W'(tag_idx(32'(um_tail_i[i]), PTR_W));
    end

    for (genvar k = 0; k < DEQ_WIDTH; k++) begin : g_rd
        assign rd_idx[k]     = PTR_W'(tag_idx(32'(um_head_i[k]), PTR_W));
        assign deq_data_o[k] = mem[rd_idx[k]];
    end

    // Payload is deliberately left unreset; entry_vld alone says what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (enq_fire[i]) mem[wr_idx[i]] <= enq_data_i[i];
        end
    end

    always_comb begin
        vld_nxt = entry_vld;
        err_hit = (um_avail_cnt_i > CNT_W'(ENTRY_COUNT));
        for (int k = 0; k < DEQ_WIDTH; k++) begin
            if (deq_fire[k]) begin
                if (!entry_vld[rd_idx[k]]) err_hit = 1'b1;
                vld_nxt[rd_idx[k]] = 1'b0;
            end
        end
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (enq_fire[i]) begin
                if (entry_vld[wr_idx[i]]) err_hit = 1'b1;
                vld_nxt[wr_idx[i]] = 1'b1;
            end
        end
    end

    // Flush wipes occupancy but leaves the sticky error untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_vld <= '0;
            err_q     <= 1'b0;
        end else if (flush_i) begin
            entry_vld <= '0;
        end else begin
            entry_vld <= vld_nxt;
            if (err_hit) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mport_queue_datapath.sv
// Randomized bench for mport_queue_datapath; the bench plays the pointer manager and keeps a FIFO model.
module tb_mport_queue_datapath;

    localparam int EC = 6;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       enq_vld = '0;
    logic [1:0][DW-1:0] enq_data = '0;
    logic [1:0]       enq_rdy;
    logic [1:0]       deq_vld;
    logic [1:0][DW-1:0] deq_data;
    logic [1:0]       deq_rdy = '0;
    logic [1:0][3:0]  um_tail = '0;
    logic [1:0][3:0]  um_head = '0;
    logic [2:0]       avail_cnt = 3'(EC);
    logic [1:0]       enq_fire;
    logic [1:0]       deq_fire;
    logic             err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    int head_p = 0, tail_p = 0;
    bit head_f = 1'b0, tail_f = 1'b0;
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    mport_queue_datapath #(
        .ENTRY_COUNT(EC), .ENQ_WIDTH(2), .DEQ_WIDTH(2), .DATA_WIDTH(DW), .FLAG_EN(1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush),
        .enq_vld_i      (enq_vld),
        .enq_data_i     (enq_data),
        .enq_rdy_o      (enq_rdy),
        .deq_vld_o      (deq_vld),
        .deq_data_o     (deq_data),
        .deq_rdy_i      (deq_rdy),
        .um_tail_i      (um_tail),
        .um_head_i      (um_head),
        .um_avail_cnt_i (avail_cnt),
        .um_enq_fire_o  (enq_fire),
        .um_deq_fire_o  (deq_fire),
        .err_o          (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] tag_of(input int p, input bit f, input int n);
        int  r = p + n;
        bit  g = f;
        if (r >= EC) begin r -= EC; g = ~g; end
        return {g, 3'(r)};
    endfunction

    // Number of leading asserted lanes.
    function automatic int lead(input logic [1:0] v);
        int n = 0;
        for (int i = 0; i < 2; i++) if (v[i] && n == i) n++;
        return n;
    endfunction

    // One cycle: drive at negedge, check combinational outputs, then advance the model at posedge.
    // ovr >= 0 forces the avail count to a value the model does not agree with.
    task automatic step(input logic [1:0] ev, input logic [1:0] dr, input logic fl, input int ovr);
        int avail, occ, n_enq, n_deq;
        logic [1:0] e_rdy, e_dv;
        logic [1:0][DW-1:0] d;
        @(negedge clk);
        d[0] = DW'($urandom);
        d[1] = DW'($urandom);
        avail = (ovr >= 0) ? ovr : EC - q.size();
        occ   = EC - avail;
        enq_vld = ev; enq_data = d; deq_rdy = dr; flush = fl;
        avail_cnt = 3'(avail);
        for (int i = 0; i < 2; i++) begin
            um_tail[i] = tag_of(tail_p, tail_f, i);
            um_head[i] = tag_of(head_p, head_f, i);
        end
        #1;
        n_enq = fl ? 0 : ((lead(ev) < avail) ? lead(ev) : avail);
        n_deq = fl ? 0 : ((lead(dr) < occ) ? lead(dr) : occ);
        for (int i = 0; i < 2; i++) begin
            e_rdy[i] = !fl && (avail > i) && (lead(ev) >= i);
            e_dv[i]  = !fl && (occ > i) && (lead(dr) >= i);
        end
        chk("enq_rdy", 32'(enq_rdy), 32'(e_rdy));
        chk("enq_fire", 32'(enq_fire), 32'((1 << n_enq) - 1));
        chk("deq_vld", 32'(deq_vld), 32'(e_dv));
        chk("deq_fire", 32'(deq_fire), 32'((1 << n_deq) - 1));
        chk("err", 32'(err), 32'(exp_err));
        for (int k = 0; k < 2; k++)
            if (e_dv[k] && k < q.size()) chk($sformatf("deq_data%0d", k), 32'(deq_data[k]), 32'(q[k]));
        @(posedge clk);
        if (fl) begin
            q.delete();
            tail_p = head_p; tail_f = head_f;
        end else begin
            if (n_deq > q.size() || avail > EC) exp_err = 1'b1;
            for (int k = 0; k < n_deq; k++) begin
                if (q.size() > 0) begin
                    void'(q.pop_front());
                    {head_f, head_p} = {tag_of(head_p, head_f, 1)[3], int'(tag_of(head_p, head_f, 1)[2:0])};
                end
            end
            for (int i = 0; i < n_enq; i++) begin
                q.push_back(d[i]);
                {tail_f, tail_p} = {tag_of(tail_p, tail_f, 1)[3], int'(tag_of(tail_p, tail_f, 1)[2:0])};
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        q.delete();
        head_p = 0; tail_p = 0; head_f = 1'b0; tail_f = 1'b0; exp_err = 1'b0;
        enq_vld = '0; deq_rdy = '0; flush = 1'b0; avail_cnt = 3'(EC);
        um_tail = '0; um_head = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_deq_vld", 32'(deq_vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Two lanes in, visible the next cycle in order.
        step(2'b11, 2'b00, 1'b0, -1);
        step(2'b00, 2'b11, 1'b0, -1);

        // Fill to avail=1, then only lane0 may fire; full blocks everything incl. gap pattern.
        step(2'b11, 2'b00, 1'b0, -1);
        step(2'b11, 2'b00, 1'b0, -1);
        step(2'b01, 2'b00, 1'b0, -1);
        step(2'b11, 2'b00, 1'b0, -1);
        step(2'b10, 2'b10, 1'b0, -1);
        step(2'b11, 2'b11, 1'b0, -1);
        step(2'b10, 2'b00, 1'b0, -1);

        // Traffic across the index 5 -> 0 wrap.
        for (int n = 0; n < 12; n++)
            step(2'($urandom_range(3)), 2'($urandom_range(3)), 1'b0, -1);

        // Flush with 4 entries held and both sides requesting.
        for (int n = 0; n < 8 && q.size() > 0; n++) step(2'b00, 2'b11, 1'b0, -1);
        step(2'b11, 2'b00, 1'b0, -1);
        step(2'b11, 2'b00, 1'b0, -1);
        step(2'b11, 2'b11, 1'b1, -1);
        step(2'b00, 2'b11, 1'b0, -1);
        step(2'b11, 2'b00, 1'b0, -1);
        step(2'b00, 2'b11, 1'b0, -1);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 300; n++)
            step(2'($urandom_range(3)), 2'($urandom_range(3)), ($urandom_range(31) == 0), -1);

        // Lie about avail so dequeues hit empty entries; error must stick until reset.
        step(2'b00, 2'b00, 1'b1, -1);
        step(2'b00, 2'b11, 1'b0, 2);
        step(2'b00, 2'b00, 1'b0, -1);
        step(2'b11, 2'b00, 1'b1, -1);
        step(2'b00, 2'b00, 1'b0, -1);
        chk("err_sticky", 32'(err), 32'd1);

        // Mid-operation reset clears state.
        step(2'b11, 2'b00, 1'b0, -1);
        do_reset();
        step(2'b11, 2'b00, 1'b0, -1);
        step(2'b00, 2'b11, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
